iir_coef_ctl: RTL and testbench

//  Coefficient controller for the iir4 filter. Holds a shadow coefficient bank written over a simple

---
 rtl/iir_coef_ctl.sv | 150 +++++++++++++++
 tb/tb_iir_coef_ctl.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_coef_ctl.sv
// Coefficient controller for iir4: shadow bank written over a config port, committed to the
// live coefficients only at a packet boundary once every in-flight beat has left the filter.
module iir_coef_ctl #(
    parameter int W     = 16,
    parameter int CW    = 6,
    parameter int RST_B = 1,
    parameter int RST_A = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [2:0]    cfg_addr,
    input  logic [W-1:0]  cfg_wdata,
    input  logic          cfg_commit,
    output logic          cfg_pending,
    output logic          cfg_done,
    output logic [W-1:0]  B0,
    output logic [W-1:0]  B1,
    output logic [W-1:0]  B2,
    output logic [W-1:0]  B3,
    output logic [W-1:0]  A1,
    output logic [W-1:0]  A2,
    output logic [W-1:0]  A3,
    input  logic [W-1:0]  uc_d0,
    input  logic [3:0]    uc_mflags,
    output logic [1:0]    cu_sflags,
    output logic [W-1:0]  cd_d0,
    output logic [3:0]    cd_mflags,
    input  logic [1:0]    dc_sflags,
    input  logic [3:0]    mon_mflags,
    input  logic [1:0]    mon_sflags,
    output logic [1:0]    dbg_state
);
    // Handshake: a beat moves when its V flag is 1 and the receiver's busy flag is 0 in
    // the same cycle; V never depends on busy, busy may depend on anything registered.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DRAIN = 2'd2,
        SWAP  = 2'd3
    } state_t;

    localparam logic [CW-1:0] INFL_MAX = {CW{1'b1}};
    localparam logic [W-1:0]  B_INIT   = W'(RST_B);
    localparam logic [W-1:0]  A_INIT   = W'(RST_A);

    state_t          state;
    state_t          state_nxt;
    logic            in_pkt;
    logic [CW-1:0]   infl;
    logic            hold;
    logic            swap_en;
    logic            acc_in;
    logic            acc_out;
    logic [W-1:0]    shadow [7];
    logic [W-1:0]    active [7];
    logic            unused_bits;

    assign cd_d0     = uc_d0;
    assign cd_mflags = {uc_mflags[3:1], uc_mflags[0] & ~hold};
    assign cu_sflags = {1'b0, dc_sflags[0] | hold};
    assign acc_in    = cd_mflags[0] & ~dc_sflags[0];
    assign acc_out   = mon_mflags[0] & ~mon_sflags[0];
    assign dbg_state = state;

    assign unused_bits = ^{mon_mflags[3:1], mon_sflags[1], dc_sflags[1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (cfg_commit) state_nxt = ARMED;
            ARMED:   if (!in_pkt) state_nxt = DRAIN;
            DRAIN:   if (infl == '0 && !acc_out) state_nxt = SWAP;
            SWAP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Once a commit is seen, new packets are held off; the open one finishes untouched.
    always_comb begin
        cfg_pending = (state != IDLE);
        cfg_done    = (state == SWAP);
        swap_en     = (state == SWAP);
        hold        = ((state != IDLE) && !in_pkt) || (infl == INFL_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_pkt <= 1'b0;
        end else if (acc_in) begin
            if (uc_mflags[3] || uc_mflags[1]) begin
                in_pkt <= 1'b0;
            end else if (uc_mflags[2]) begin
                in_pkt <= 1'b1;
            end
        end
    end

    // Increment at max cannot happen because hold blocks acc_in there.
    always_ff @(posedge clk) begin
        if (rst) begin
            infl <= '0;
        end else if (acc_in && !acc_out) begin
            infl <= infl + 1'b1;
        end else if (!acc_in && acc_out && infl != '0) begin
            infl <= infl - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 7; i++) begin
                shadow[i] <= (i < 4) ? B_INIT : A_INIT;
            end
        end else if (cfg_we && cfg_addr != 3'd7) begin
            shadow[cfg_addr] <= cfg_wdata;
        end
    end

    // Active takes the shadow value from before any same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 7; i++) begin
                active[i] <= (i < 4) ? B_INIT : A_INIT;
            end
        end else if (swap_en) begin
            for (int i = 0; i < 7; i++) begin
                active[i] <= shadow[i];
            end
        end
    end

    assign B0 = active[0];
    assign B1 = active[1];
    assign B2 = active[2];
    assign B3 = active[3];
    assign A1 = active[4];
    assign A2 = active[5];
    assign A3 = active[6];

endmodule

// File: tb/tb_iir_coef_ctl.sv
// Directed bench for iir_coef_ctl: drives config, upstream beats and iir4 output flags
// by hand and compares against hand-computed expectations.
module tb_iir_coef_ctl;
    localparam int W = 16;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [2:0]    cfg_addr;
    logic [W-1:0]  cfg_wdata;
    logic          cfg_commit;
    logic          cfg_pending;
    logic          cfg_done;
    logic [W-1:0]  B0, B1, B2, B3, A1, A2, A3;
    logic [W-1:0]  uc_d0;
    logic [3:0]    uc_mflags;
    logic [1:0]    cu_sflags;
    logic [W-1:0]  cd_d0;
    logic [3:0]    cd_mflags;
    logic [1:0]    dc_sflags;
    logic [3:0]    mon_mflags;
    logic [1:0]    mon_sflags;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    iir_coef_ctl #(.W(W), .CW(6), .RST_B(1), .RST_A(2)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_commit(cfg_commit), .cfg_pending(cfg_pending), .cfg_done(cfg_done),
        .B0(B0), .B1(B1), .B2(B2), .B3(B3), .A1(A1), .A2(A2), .A3(A3),
        .uc_d0(uc_d0), .uc_mflags(uc_mflags), .cu_sflags(cu_sflags),
        .cd_d0(cd_d0), .cd_mflags(cd_mflags), .dc_sflags(dc_sflags),
        .mon_mflags(mon_mflags), .mon_sflags(mon_sflags), .dbg_state(dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic write_shadow(input logic [2:0] addr, input logic [W-1:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        tick;
        cfg_we    = 1'b0;
    endtask

    task automatic set_beat(input logic a, input logic f, input logic l, input logic v,
                            input logic [W-1:0] d);
        uc_mflags = {a, f, l, v};
        uc_d0     = d;
    endtask

    task automatic check_coefs(input string tag, input logic [W-1:0] b0, input logic [W-1:0] b1,
                               input logic [W-1:0] b2, input logic [W-1:0] b3, input logic [W-1:0] a1,
                               input logic [W-1:0] a2, input logic [W-1:0] a3);
        check({tag, "_b0"}, 32'(B0), 32'(b0));
        check({tag, "_b1"}, 32'(B1), 32'(b1));
        check({tag, "_b2"}, 32'(B2), 32'(b2));
        check({tag, "_b3"}, 32'(B3), 32'(b3));
        check({tag, "_a1"}, 32'(A1), 32'(a1));
        check({tag, "_a2"}, 32'(A2), 32'(a2));
        check({tag, "_a3"}, 32'(A3), 32'(a3));
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_commit = 1'b0;
        uc_d0 = '0; uc_mflags = '0; dc_sflags = '0; mon_mflags = '0; mon_sflags = '0;
        tick;
        tick;
        rst = 1'b0;
        #1;
        check_coefs("rst", 1, 1, 1, 1, 2, 2, 2);
        check("rst_pending", 32'(cfg_pending), 0);
        check("rst_done", 32'(cfg_done), 0);
        check("rst_busy", 32'(cu_sflags), 0);
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));

        // Idle commit: done three cycles after the commit cycle
        write_shadow(3'd0, 16'd5);
        write_shadow(3'd4, 16'd7);
        check("t1_b0_not_live", 32'(B0), 1);
        cfg_commit = 1'b1;
        #1;
        check("t1_pending_commit_cycle", 32'(cfg_pending), 0);
        tick;
        cfg_commit = 1'b0;
        #1;
        check("t1_state_armed", 32'(dbg_state), 32'(S_ARMED));
        check("t1_pending", 32'(cfg_pending), 1);
        tick;
        #1;
        check("t1_done_c2", 32'(cfg_done), 0);
        tick;
        #1;
        check("t1_done_c3", 32'(cfg_done), 1);
        check("t1_b0_in_swap", 32'(B0), 1);
        tick;
        #1;
        check("t1_done_after", 32'(cfg_done), 0);
        check("t1_pending_after", 32'(cfg_pending), 0);
        check_coefs("t1", 5, 1, 1, 1, 7, 2, 2);

        // Commit two beats into a six-beat packet
        write_shadow(3'd1, 16'd9);
        for (int k = 0; k < 6; k++) begin
            set_beat(1'b0, k == 0, k == 5, 1'b1, 16'(100 + k));
            cfg_commit = (k == 2);
            #1;
            check("t2_beat_valid", 32'(cd_mflags[0]), 1);
            check("t2_beat_busy", 32'(cu_sflags[0]), 0);
            check("t2_beat_data", 32'(cd_d0), 32'(100 + k));
            check("t2_pending", 32'(cfg_pending), (k > 2) ? 1 : 0);
            tick;
            cfg_commit = 1'b0;
        end
        set_beat(1'b0, 1'b1, 1'b0, 1'b1, 16'd150);
        #1;
        check("t2_after_l_state", 32'(dbg_state), 32'(S_ARMED));
        check("t2_after_l_busy", 32'(cu_sflags[0]), 1);
        check("t2_after_l_gated", 32'(cd_mflags[0]), 0);
        tick;
        #1;
        check("t2_drain_state", 32'(dbg_state), 32'(S_DRAIN));
        check("t2_drain_busy", 32'(cu_sflags), 1);
        set_beat(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        mon_mflags = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("t2_draining", 32'(dbg_state), 32'(S_DRAIN));
            tick;
        end
        mon_mflags = 4'b0000;
        #1;
        check("t2_last_drain", 32'(dbg_state), 32'(S_DRAIN));
        check("t2_b1_before", 32'(B1), 1);
        tick;
        #1;
        check("t2_swap_done", 32'(cfg_done), 1);
        check("t2_swap_busy", 32'(cu_sflags[0]), 1);
        check("t2_swap_b1_old", 32'(B1), 1);
        tick;
        #1;
        check("t2_post_busy", 32'(cu_sflags[0]), 0);
        check("t2_post_b1", 32'(B1), 9);

        // F beat arriving while a commit is pending waits for the new bank
        write_shadow(3'd2, 16'd3);
        cfg_commit = 1'b1;
        tick;
        cfg_commit = 1'b0;
        set_beat(1'b0, 1'b1, 1'b0, 1'b1, 16'd200);
        for (int i = 0; i < 2; i++) begin
            #1;
            check("t3_f_held", 32'(cd_mflags[0]), 0);
            check("t3_busy", 32'(cu_sflags[0]), 1);
            tick;
        end
        #1;
        check("t3_swap_done", 32'(cfg_done), 1);
        check("t3_swap_held", 32'(cd_mflags[0]), 0);
        check("t3_swap_b2_old", 32'(B2), 1);
        tick;
        #1;
        check("t3_released", 32'(cd_mflags[0]), 1);
        check("t3_b2_new", 32'(B2), 3);
        tick;
        set_beat(1'b0, 1'b0, 1'b1, 1'b1, 16'd201);
        #1;
        check("t3_l_pass", 32'(cd_mflags[0]), 1);
        tick;
        set_beat(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        mon_mflags = 4'b0001;
        tick;
        tick;
        mon_mflags = 4'b0000;

        // Single F&L beat opens no packet; downstream busy freezes DRAIN
        write_shadow(3'd3, 16'd11);
        set_beat(1'b0, 1'b1, 1'b1, 1'b1, 16'd300);
        cfg_commit = 1'b1;
        #1;
        check("t4_fl_pass", 32'(cd_mflags[0]), 1);
        tick;
        set_beat(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        cfg_commit = 1'b0;
        #1;
        check("t4_armed", 32'(dbg_state), 32'(S_ARMED));
        tick;
        #1;
        check("t4_fl_no_pkt", 32'(dbg_state), 32'(S_DRAIN));
        mon_mflags = 4'b0001;
        mon_sflags = 2'b01;
        for (int i = 0; i < 20; i++) begin
            #1;
            check("t4_busy_drain", 32'(dbg_state), 32'(S_DRAIN));
            tick;
        end
        mon_sflags = 2'b00;
        #1;
        check("t4_out_beat", 32'(dbg_state), 32'(S_DRAIN));
        tick;
        mon_mflags = 4'b0000;
        #1;
        check("t4_drained", 32'(dbg_state), 32'(S_DRAIN));
        check("t4_b3_old", 32'(B3), 1);
        tick;
        #1;
        check("t4_done", 32'(cfg_done), 1);
        tick;
        #1;
        check("t4_b3_new", 32'(B3), 11);

        // Spurious output beats at zero in-flight, then address 7 write
        mon_mflags = 4'b0001;
        tick;
        tick;
        mon_mflags = 4'b0000;
        write_shadow(3'd7, 16'hdead);
        cfg_commit = 1'b1;
        tick;
        cfg_commit = 1'b0;
        tick;
        tick;
        #1;
        check("clamp_done_c3", 32'(cfg_done), 1);
        tick;
        #1;
        check_coefs("addr7", 5, 9, 3, 11, 7, 2, 2);

        // Write during SWAP lands in shadow only
        write_shadow(3'd0, 16'h0021);
        cfg_commit = 1'b1;
        tick;
        cfg_commit = 1'b0;
        tick;
        tick;
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 16'h0077;
        #1;
        check("swapwr_done", 32'(cfg_done), 1);
        tick;
        cfg_we = 1'b0;
        #1;
        check("swapwr_b0_pre", 32'(B0), 32'h21);
        cfg_commit = 1'b1;
        tick;
        cfg_commit = 1'b0;
        tick;
        tick;
        #1;
        check("swapwr2_done", 32'(cfg_done), 1);
        tick;
        #1;
        check("swapwr_b0_post", 32'(B0), 32'h77);

        // Reset while in DRAIN abandons the commit and the shadow bank
        write_shadow(3'd5, 16'd44);
        set_beat(1'b0, 1'b1, 1'b1, 1'b1, 16'd400);
        cfg_commit = 1'b1;
        tick;
        set_beat(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        cfg_commit = 1'b0;
        tick;
        #1;
        check("t5_in_drain", 32'(dbg_state), 32'(S_DRAIN));
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        check("t5_pending", 32'(cfg_pending), 0);
        check("t5_busy", 32'(cu_sflags[0]), 0);
        check("t5_state", 32'(dbg_state), 32'(S_IDLE));
        check("t5_done", 32'(cfg_done), 0);
        check_coefs("t5_rst", 1, 1, 1, 1, 2, 2, 2);
        cfg_commit = 1'b1;
        tick;
        cfg_commit = 1'b0;
        tick;
        tick;
        #1;
        check("t5_recommit_done", 32'(cfg_done), 1);
        tick;
        #1;
        check_coefs("t5_shadow_lost", 1, 1, 1, 1, 2, 2, 2);

        // Second commit in ARMED is ignored; abort beat closes the packet
        write_shadow(3'd5, 16'd66);
        set_beat(1'b0, 1'b1, 1'b0, 1'b1, 16'd500);
        cfg_commit = 1'b1;
        tick;
        set_beat(1'b0, 1'b0, 1'b0, 1'b1, 16'd501);
        #1;
        check("t6_armed", 32'(dbg_state), 32'(S_ARMED));
        check("t6_mid_pass", 32'(cu_sflags[0]), 0);
        tick;
        cfg_commit = 1'b0;
        set_beat(1'b1, 1'b0, 1'b0, 1'b1, 16'd502);
        #1;
        check("t6_abort_pass", 32'(cd_mflags[0]), 1);
        tick;
        set_beat(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        #1;
        check("t6_abort_state", 32'(dbg_state), 32'(S_ARMED));
        check("t6_abort_clears", 32'(cu_sflags[0]), 1);
        tick;
        #1;
        check("t6_drain", 32'(dbg_state), 32'(S_DRAIN));
        mon_mflags = 4'b0001;
        tick;
        tick;
        tick;
        mon_mflags = 4'b0000;
        #1;
        check("t6_drained", 32'(dbg_state), 32'(S_DRAIN));
        tick;
        #1;
        check("t6_done", 32'(cfg_done), 1);
        tick;
        #1;
        check("t6_a2_new", 32'(A2), 66);
        for (int i = 0; i < 4; i++) begin
            check("t6_single_done", 32'(cfg_done), 0);
            check("t6_idle", 32'(dbg_state), 32'(S_IDLE));
            tick;
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
